alu_imm_pipe: RTL and testbench
===============================

Name: alu_imm_pipe

Overview:
- Parametrised, pipelined successor of the team's immediate-operand ALU unit.
- Takes a DATA_W-bit register operand and an IMM_W-bit immediate, extends the immediate, and executes one of eight immediate operations.
- Returns result plus carry/sign/overflow/zero flags through a 2-stage valid/ready pipeline.
- Sits between decode and register-file writeback in the multi-cycle datapath; replaces the enable-edge-triggered unit.

Parameters:
- DATA_W, 32, operand/result width (must be ≥ 8 and a power of two).
- IMM_W, 16, immediate width (must be ≤ DATA_W).
- SH_W, $clog2(DATA_W), shift-amount width taken from imm[SH_W-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts request this cycle.
- inp1  in  DATA_W  register operand.
- imm  in  IMM_W  immediate operand.
- func  in  3  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- res  out  DATA_W  result.
- carry_flag  out  1  carry/borrow.
- sign_flag  out  1  res[DATA_W-1].
- overflow_flag  out  1  signed overflow.
- zero_flag  out  1  res == 0.

Behaviour:
- Reset: synchronous on rising clk with rst=1. Clears s1_valid, out_valid, res, and all flags to 0. A reset mid-flight drops both in-flight ops silently.
- Handshake: transfer on valid&&ready at each side.
  - in_ready = !s1_valid || advance, where advance = !out_valid || out_ready.
  - Stage-2 output registers and flags hold stable while out_valid && !out_ready.
  - in_valid may drop without transfer; no requirement to hold.
- Stage 1 (accept):
  - Registers inp1 and func.
  - Registers imm_ext: zero-extended for func 3,4,5 (ANDI/ORI/XORI); sign-extended otherwise.
- Stage 2 (execute, when s1_valid && advance): computes res and flags, sets out_valid=1. Otherwise, out_valid clears on out_ready.
- Latency and throughput:
  - Latency: 2 cycles from accepted input to out_valid under no backpressure.
  - Throughput: 1 op/cycle.
- Operations (func):
  - 0 ADDI: res = inp1 + imm_ext. carry = bit DATA_W of the (DATA_W+1)-bit sum. ovf = (inp1[msb]==imm_ext[msb]) && (res[msb]!=inp1[msb]).
  - 1 NEGI: res = -imm_ext (2's complement). carry=0. ovf=1 only when imm_ext is the most-negative value (only reachable when IMM_W==DATA_W).
  - 2 SUBI: res = inp1 - imm_ext. carry = borrow (inp1 < imm_ext unsigned). ovf = (inp1[msb]!=imm_ext[msb]) && (res[msb]!=inp1[msb]).
  - 3 ANDI, 4 ORI, 5 XORI: bitwise with zero-extended imm. carry=0, ovf=0.
  - 6 SLLI: res = inp1 << imm[SH_W-1:0]. carry = last bit shifted out (0 if shift is 0). ovf=0.
  - 7 SRAI: arithmetic right shift by imm[SH_W-1:0]. carry = last bit shifted out (0 if shift is 0). ovf=0.
- Flags: zero and sign are always derived from res, for every func.
- Boundaries:
  - Simultaneous stage-2 drain and stage-1 fill in the same cycle is legal (full throughput).
  - Shift amounts never exceed DATA_W-1; higher imm bits are ignored.
  - ADDI wrap-around: 0x7FFFFFFF + 1 gives ovf=1, carry=0; 0xFFFFFFFF + 1 gives res=0, carry=1, zero=1.

Decomposition:
- Shared package alu_pkg:
  - func encodings: FN_ADDI..FN_SRAI, 3 bits.
  - flag struct order {carry, sign, overflow, zero}.
  - Default widths.
- One natural sub-module: alu_imm_core, the purely combinational operation/flag evaluator on (inp1, imm_ext, imm shift field, func). Reusable by the register-register ALU; the pipeline/handshake wrapper stays in alu_imm_pipe.

Test Plan:
- ADDI inp1=0x7FFFFFFF, imm=0x0001 -> after 2 cycles: res=0x80000000, ovf=1, sign=1, carry=0, zero=0.
- ADDI inp1=0x00000005, imm=0xFFFB (−5) -> res=0, zero=1, carry=1, ovf=0. NEGI imm=0x8000 -> res=0x00008000, ovf=0, sign=0.
- SUBI inp1=3, imm=5 -> res=0xFFFFFFFE, carry(borrow)=1, sign=1. ANDI inp1=0xFFFFFFFF, imm=0x8001 -> res=0x00008001 (zero-extended).
- SLLI inp1=0x80000001, imm=1 -> res=0x00000002, carry=1. SRAI inp1=0x80000000, imm=31 -> res=0xFFFFFFFF, carry=0.
- Backpressure: 4 back-to-back ADDIs with out_ready low for 3 cycles:
  - in_ready deasserts after 2 accepts.
  - res is held stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
- Assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, res=0, all flags 0. The next accepted op completes normally 2 cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the immediate-operand ALU family: function codes,
// flag bundle layout and default datapath widths.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMM_W_DEF  = 16;

  typedef enum logic [2:0] {
    FN_ADDI = 3'd0,
    FN_NEGI = 3'd1,
    FN_SUBI = 3'd2,
    FN_ANDI = 3'd3,
    FN_ORI  = 3'd4,
    FN_XORI = 3'd5,
    FN_SLLI = 3'd6,
    FN_SRAI = 3'd7
  } func_e;

  typedef struct packed {
    logic carry;
    logic sign;
    logic overflow;
    logic zero;
  } flags_t;

  // Logical ops take the immediate zero-extended so masks keep their upper bits clear.
  function automatic logic zero_ext_func(input func_e f);
    return (f == FN_ANDI) || (f == FN_ORI) || (f == FN_XORI);
  endfunction

endpackage

// File: rtl/alu_imm_core.sv
// Combinational operation/flag evaluator for one ALU op on an already-extended
// immediate; shared with the register-register ALU.
module alu_imm_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] inp1,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [SH_W-1:0]   sh,
  input  func_e             func,
  output logic [DATA_W-1:0] res,
  output flags_t            flags
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]        sum;
  logic [DATA_W:0]        diff;
  logic [DATA_W:0]        shl;
  logic signed [DATA_W:0] sra;
  logic                   carry;
  logic                   ovf;

  assign sum  = {1'b0, inp1} + {1'b0, imm_ext};
  assign diff = {1'b0, inp1} - {1'b0, imm_ext};
  // One guard bit on each shifter catches the last bit shifted out (0 for a zero shift).
  assign shl  = {1'b0, inp1} << sh;
  assign sra  = $signed({inp1, 1'b0}) >>> sh;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (func)
      FN_ADDI: begin
        res   = sum[MSB:0];
        carry = sum[DATA_W];
        ovf   = (inp1[MSB] == imm_ext[MSB]) && (sum[MSB] != inp1[MSB]);
      end
      FN_NEGI: begin
        res = -imm_ext;
        ovf = (imm_ext == MOST_NEG);
      end
      FN_SUBI: begin
        res   = diff[MSB:0];
        carry = diff[DATA_W];
        ovf   = (inp1[MSB] != imm_ext[MSB]) && (diff[MSB] != inp1[MSB]);
      end
      FN_ANDI: res = inp1 & imm_ext;
      FN_ORI:  res = inp1 | imm_ext;
      FN_XORI: res = inp1 ^ imm_ext;
      FN_SLLI: begin
        res   = shl[MSB:0];
        carry = shl[DATA_W];
      end
      FN_SRAI: begin
        res   = sra[DATA_W:1];
        carry = sra[0];
      end
      default: begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

  assign flags = '{carry: carry, sign: res[MSB], overflow: ovf, zero: (res == '0)};

endmodule

// File: rtl/alu_imm_pipe.sv
// Two-stage valid/ready immediate ALU: stage 1 captures operands and the
// extended immediate, stage 2 registers the result and flags.
module alu_imm_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] inp1,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              carry_flag,
  output logic              sign_flag,
  output logic              overflow_flag,
  output logic              zero_flag
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_inp1;
  logic [DATA_W-1:0] s1_imm_ext;
  func_e             s1_func;

  logic              advance;
  logic              accept;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] core_res;
  flags_t            core_flags;
  flags_t            flags_q;

  // Stage 2 may take a new op whenever it is empty or its result leaves this cycle.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  always_comb begin
    imm_zext              = '0;
    imm_zext[IMM_W-1:0]   = imm;
    imm_sext              = {DATA_W{imm[IMM_W-1]}};
    imm_sext[IMM_W-1:0]   = imm;
  end

  assign imm_ext = zero_ext_func(func_e'(func)) ? imm_zext : imm_sext;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_inp1    <= inp1;
      s1_imm_ext <= imm_ext;
      s1_func    <= func_e'(func);
    end
  end

  alu_imm_core #(
    .DATA_W(DATA_W),
    .SH_W  (SH_W)
  ) u_core (
    .inp1   (s1_inp1),
    .imm_ext(s1_imm_ext),
    .sh     (s1_imm_ext[SH_W-1:0]),
    .func   (s1_func),
    .res    (core_res),
    .flags  (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      flags_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          res     <= core_res;
          flags_q <= core_flags;
        end
      end
    end
  end

  assign carry_flag    = flags_q.carry;
  assign sign_flag     = flags_q.sign;
  assign overflow_flag = flags_q.overflow;
  assign zero_flag     = flags_q.zero;

endmodule

// File: tb/tb_alu_imm_pipe.sv
// Self-checking bench for alu_imm_pipe: directed vectors, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_alu_imm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inp1 = '0;
  logic [15:0] imm = '0;
  logic [2:0]  func = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        carry_flag, sign_flag, overflow_flag, zero_flag;

  int tests_run = 0;
  int tests_failed = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  alu_imm_pipe #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .imm(imm), .func(func),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res),
    .carry_flag(carry_flag), .sign_flag(sign_flag),
    .overflow_flag(overflow_flag), .zero_flag(zero_flag)
  );

  // Reference: {res, carry, sign, overflow, zero} from plain 64-bit arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [15:0] i,
                                        input logic [2:0] f);
    logic [31:0] ie, r;
    logic [63:0] u;
    logic c, o;
    longint sa, si, w;
    int sh;
    ie = (f >= 3 && f <= 5) ? {16'h0000, i} : {{16{i[15]}}, i};
    sa = longint'($signed(a));
    si = longint'($signed(ie));
    sh = int'(i[4:0]);
    c = 1'b0; o = 1'b0; r = '0; w = 0;
    case (f)
      3'd0: begin
        w = sa + si; r = w[31:0];
        u = {32'h0, a} + {32'h0, ie}; c = u[32];
        o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      3'd1: begin
        w = -si; r = w[31:0];
        o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      3'd2: begin
        w = sa - si; r = w[31:0];
        c = (a < ie);
        o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      3'd3: r = a & ie;
      3'd4: r = a | ie;
      3'd5: r = a ^ ie;
      3'd6: begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32-sh];
      end
      default: begin
        r = $signed(a) >>> sh;
        c = (sh == 0) ? 1'b0 : a[sh-1];
      end
    endcase
    return {r, c, r[31], o, (r == 32'h0)};
  endfunction

  // One cycle: drive at negedge, sample #1 later; the following posedge commits.
  task automatic drive_cycle(input logic r, input logic v, input logic [31:0] a,
                             input logic [15:0] i, input logic [2:0] f, input logic ordy,
                             output logic acc, output logic fire, output logic ovld,
                             output logic [31:0] ores, output logic [3:0] oflg,
                             output logic irdy);
    @(negedge clk);
    rst = r; in_valid = v; inp1 = a; imm = i; func = f; out_ready = ordy;
    #1;
    acc  = v && in_ready && !r;
    fire = out_valid && ordy && !r;
    ovld = out_valid;
    ores = res;
    oflg = {carry_flag, sign_flag, overflow_flag, zero_flag};
    irdy = in_ready;
  endtask

  task automatic test_reset();
    logic acc, fire, ovld, irdy;
    logic [31:0] ores;
    logic [3:0] oflg;
    drive_cycle(1, 0, 0, 0, 0, 0, acc, fire, ovld, ores, oflg, irdy);
    drive_cycle(1, 0, 0, 0, 0, 0, acc, fire, ovld, ores, oflg, irdy);
    drive_cycle(0, 0, 0, 0, 0, 0, acc, fire, ovld, ores, oflg, irdy);
    tests_run++;
    if (ovld !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid got=%b want=0", ovld);
    end
    tests_run++;
    if (ores !== 32'h0 || oflg !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_res_flags got res=%h flags=%b want 0/0000", ores, oflg);
    end
    tests_run++;
    if (irdy !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready got=%b want=1", irdy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] da [10] = '{32'h7FFFFFFF, 32'h00000005, 32'h00000000, 32'h00000003,
                             32'hFFFFFFFF, 32'h80000001, 32'h80000000, 32'hFFFFFFFF,
                             32'h12340000, 32'hFFFFFFFF};
    logic [15:0] di [10] = '{16'h0001, 16'hFFFB, 16'h8000, 16'h0005, 16'h8001,
                             16'h0001, 16'h001F, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic [2:0]  df [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0, 3'd4, 3'd5};
    logic [31:0] dr [10] = '{32'h80000000, 32'h00000000, 32'h00008000, 32'hFFFFFFFE,
                             32'h00008001, 32'h00000002, 32'hFFFFFFFF, 32'h00000000,
                             32'h1234FFFF, 32'hFFFF0000};
    logic [3:0]  dfl [10] = '{4'b0110, 4'b1001, 4'b0000, 4'b1100, 4'b0000,
                              4'b1000, 4'b0100, 4'b1001, 4'b0000, 4'b0100};
    logic acc, fire, ovld, irdy;
    logic [31:0] ores;
    logic [3:0] oflg;
    int issued = 0, got = 0, first_acc = -1, first_fire = -1;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      if (issued < 10)
        drive_cycle(0, 1, da[issued], di[issued], df[issued], 1, acc, fire, ovld, ores, oflg, irdy);
      else
        drive_cycle(0, 0, 0, 0, 0, 1, acc, fire, ovld, ores, oflg, irdy);
      if (fire) begin
        tests_run++;
        if (ores !== dr[got] || oflg !== dfl[got]) begin
          tests_failed++;
          $display("FAIL directed[%0d] got res=%h flags=%b want res=%h flags=%b",
                   got, ores, oflg, dr[got], dfl[got]);
        end
        if (first_fire < 0) first_fire = cyc;
        got++;
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        issued++;
      end
    end
    tests_run++;
    if (got != 10) begin
      tests_failed++; $display("FAIL directed_count got=%0d want=10", got);
    end
    tests_run++;
    if (first_fire - first_acc != 2) begin
      tests_failed++; $display("FAIL directed_latency got=%0d want=2", first_fire - first_acc);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, fire, ovld, irdy;
    logic [31:0] ores, held_res, a;
    logic [3:0] oflg, held_flg;
    logic [35:0] e;
    logic [15:0] i;
    int idx = 0, got = 0;
    exp_q.delete();
    held_res = '0; held_flg = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      a = 32'h7FFFFFF0 + 32'(idx * 7);
      i = 16'(idx * 5 + 3);
      drive_cycle(0, idx < 4, a, i, 3'd0, cyc >= 3, acc, fire, ovld, ores, oflg, irdy);
      if (fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_extra_output res=%h", ores);
        end else begin
          e = exp_q.pop_front();
          if (ores !== e[35:4] || oflg !== e[3:0]) begin
            tests_failed++;
            $display("FAIL b2b_result[%0d] got res=%h flags=%b want res=%h flags=%b",
                     got, ores, oflg, e[35:4], e[3:0]);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(a, i, 3'd0));
        idx++;
      end
      if (cyc == 2) begin
        tests_run++;
        if (irdy !== 1'b0 || idx != 2 || ovld !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_stall got in_ready=%b accepts=%0d out_valid=%b want 0/2/1",
                   irdy, idx, ovld);
        end
        held_res = ores; held_flg = oflg;
      end
      if (cyc == 3) begin
        tests_run++;
        if (ores !== held_res || oflg !== held_flg) begin
          tests_failed++;
          $display("FAIL b2b_hold got res=%h flags=%b want res=%h flags=%b",
                   ores, oflg, held_res, held_flg);
        end
      end
    end
    tests_run++;
    if (got != 4) begin
      tests_failed++; $display("FAIL b2b_count got=%0d want=4", got);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, fire, ovld, irdy;
    logic [31:0] ores;
    logic [3:0] oflg;
    logic [35:0] e;
    exp_q.delete();
    drive_cycle(0, 1, 32'h11111111, 16'h0001, 3'd0, 0, acc, fire, ovld, ores, oflg, irdy);
    drive_cycle(0, 1, 32'h22222222, 16'h0002, 3'd2, 0, acc, fire, ovld, ores, oflg, irdy);
    drive_cycle(1, 0, 0, 0, 0, 0, acc, fire, ovld, ores, oflg, irdy);
    drive_cycle(0, 1, 32'h0000FFFF, 16'hFFFF, 3'd5, 1, acc, fire, ovld, ores, oflg, irdy);
    tests_run++;
    if (ovld !== 1'b0 || ores !== 32'h0 || oflg !== 4'b0000 || acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_clear got out_valid=%b res=%h flags=%b accepted=%b want 0/0/0000/1",
               ovld, ores, oflg, acc);
    end
    e = model(32'h0000FFFF, 16'hFFFF, 3'd5);
    drive_cycle(0, 0, 0, 0, 0, 1, acc, fire, ovld, ores, oflg, irdy);
    tests_run++;
    if (ovld !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_early got out_valid=%b want=0", ovld);
    end
    drive_cycle(0, 0, 0, 0, 0, 1, acc, fire, ovld, ores, oflg, irdy);
    tests_run++;
    if (ovld !== 1'b1 || ores !== e[35:4] || oflg !== e[3:0]) begin
      tests_failed++;
      $display("FAIL midreset_next got out_valid=%b res=%h flags=%b want 1/%h/%b",
               ovld, ores, oflg, e[35:4], e[3:0]);
    end
    drive_cycle(0, 0, 0, 0, 0, 1, acc, fire, ovld, ores, oflg, irdy);
  endtask

  task automatic test_random();
    logic acc, fire, ovld, irdy, v, ordy, prev_stall;
    logic [31:0] ores, a, prev_res;
    logic [3:0] oflg, prev_flg;
    logic [15:0] i;
    logic [2:0] f;
    logic [35:0] e;
    int issued = 0, got = 0, cyc = 0;
    exp_q.delete();
    prev_stall = 1'b0; prev_res = '0; prev_flg = '0;
    while ((issued < 300 || got < issued) && cyc < 3000) begin
      case ($urandom_range(0, 7))
        0: a = 32'h00000000;
        1: a = 32'h7FFFFFFF;
        2: a = 32'h80000000;
        3: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: i = 16'h0000;
        1: i = 16'hFFFF;
        2: i = 16'h8000;
        3: i = 16'h7FFF;
        default: i = 16'($urandom);
      endcase
      f = 3'($urandom_range(0, 7));
      v = (issued < 300) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      drive_cycle(0, v, a, i, f, ordy, acc, fire, ovld, ores, oflg, irdy);
      if (prev_stall) begin
        tests_run++;
        if (ovld !== 1'b1 || ores !== prev_res || oflg !== prev_flg) begin
          tests_failed++;
          $display("FAIL rand_hold got out_valid=%b res=%h flags=%b want 1/%h/%b",
                   ovld, ores, oflg, prev_res, prev_flg);
        end
      end
      if (fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rand_extra_output res=%h", ores);
        end else begin
          e = exp_q.pop_front();
          if (ores !== e[35:4] || oflg !== e[3:0]) begin
            tests_failed++;
            $display("FAIL rand_result[%0d] got res=%h flags=%b want res=%h flags=%b",
                     got, ores, oflg, e[35:4], e[3:0]);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(model(a, i, f));
        issued++;
      end
      prev_stall = ovld && !ordy;
      prev_res = ores;
      prev_flg = oflg;
      cyc++;
    end
    tests_run++;
    if (got != 300 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_count got=%0d pending=%0d want 300/0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
